// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade driver.
// LED_GAMMA_EN adds the gamma helper used by the channels.
package led_fade_pkg;

  localparam int BRIGHT_W = 8;
  localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = {BRIGHT_W{1'b1}};
  localparam logic [BRIGHT_W-1:0] BRIGHT_ONE = {{(BRIGHT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_UP   = 2'd1,
    CH_ON   = 2'd2,
    CH_DOWN = 2'd3
  } ch_state_e;

`ifdef LED_GAMMA_EN
  // Square law taking the upper byte; full scale is pinned so "on" stays solid.
  function automatic logic [BRIGHT_W-1:0] gamma_map(input logic [BRIGHT_W-1:0] b);
    logic [2*BRIGHT_W-1:0] sq;
    sq = {{BRIGHT_W{1'b0}}, b} * {{BRIGHT_W{1'b0}}, b};
    if (b == BRIGHT_MAX) begin
      gamma_map = BRIGHT_MAX;
    end else begin
      gamma_map = sq[2*BRIGHT_W-1:BRIGHT_W];
    end
  endfunction
`endif

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: OFF/UP/ON/DOWN ramp FSM, brightness register and PWM compare.
// With LED_GAMMA_EN defined the PWM compare uses the gamma-mapped level.
module led_fade_channel
  import led_fade_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                fade_tick_i,
  input  logic [BRIGHT_W-1:0] pwm_cnt_i,
  output logic                led_d_o,
  output logic                ramp_o
);

  ch_state_e           state_q, state_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic [BRIGHT_W-1:0] level_s;

  // Ramp FSM: a direction change always wins over a fade step in the same cycle.
  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    case (state_q)
      CH_OFF: begin
        bright_d = '0;
        if (req_i) begin
          state_d = CH_UP;
        end else begin
          state_d = CH_OFF;
        end
      end
      CH_UP: begin
        if (!req_i) begin
          state_d = CH_DOWN;
        end else if (fade_tick_i) begin
          if (bright_q >= (BRIGHT_MAX - BRIGHT_ONE)) begin
            state_d  = CH_ON;
            bright_d = BRIGHT_MAX;
          end else begin
            bright_d = bright_q + BRIGHT_ONE;
          end
        end else begin
          state_d = CH_UP;
        end
      end
      CH_ON: begin
        bright_d = BRIGHT_MAX;
        if (!req_i) begin
          state_d = CH_DOWN;
        end else begin
          state_d = CH_ON;
        end
      end
      CH_DOWN: begin
        if (req_i) begin
          state_d = CH_UP;
        end else if (fade_tick_i) begin
          if (bright_q <= BRIGHT_ONE) begin
            state_d  = CH_OFF;
            bright_d = '0;
          end else begin
            bright_d = bright_q - BRIGHT_ONE;
          end
        end else begin
          state_d = CH_DOWN;
        end
      end
      default: begin
        state_d  = CH_OFF;
        bright_d = '0;
      end
    endcase
  end

  // State and brightness registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= CH_OFF;
      bright_q <= '0;
    end else begin
      state_q  <= state_d;
      bright_q <= bright_d;
    end
  end

`ifdef LED_GAMMA_EN
  assign level_s = gamma_map(bright_q);
`else
  assign level_s = bright_q;
`endif

  // Full scale must be solid on, which a plain compare against 0..255 cannot give.
  assign led_d_o = (level_s == BRIGHT_MAX) || (level_s > pwm_cnt_i);
  assign ramp_o  = (state_q == CH_UP) || (state_q == CH_DOWN);

endmodule

// File: rtl/led_fade_driver.sv
// PWM fade driver for the HPS LED PIO word: input register, prescalers, PWM counter,
// per-channel ramps and registered outputs. Optional macro LED_GAMMA_EN (see channel).
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int N_LED    = 8,
  parameter int PWM_DIV  = 196,
  parameter int FADE_DIV = 195313
) (
  input  logic             FPGA_CLK_50,
  input  logic             rst_n,
  input  logic [N_LED-1:0] led_req,
  output logic [N_LED-1:0] led_out,
  output logic             gpio_mirror,
  output logic             busy
);

  localparam int PWM_PW  = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
  localparam int FADE_PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_PW-1:0]  PWM_LAST  = PWM_PW'(PWM_DIV - 1);
  localparam logic [FADE_PW-1:0] FADE_LAST = FADE_PW'(FADE_DIV - 1);
  localparam logic [PWM_PW-1:0]  PWM_INC   = PWM_PW'(1);
  localparam logic [FADE_PW-1:0] FADE_INC  = FADE_PW'(1);

  logic [N_LED-1:0]    req_q;
  logic [PWM_PW-1:0]   pwm_pre_q, pwm_pre_d;
  logic [FADE_PW-1:0]  fade_pre_q, fade_pre_d;
  logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_tick_s, fade_tick_s;
  logic [N_LED-1:0]    led_out_q;
  logic                gpio_mirror_q;
  logic                busy_q;
  logic [N_LED-1:0]    led_d_s;
  logic [N_LED-1:0]    ramp_s;

  assign pwm_tick_s  = (pwm_pre_q == PWM_LAST);
  assign fade_tick_s = (fade_pre_q == FADE_LAST);

  // Prescaler and PWM counter next-state; pwm_cnt wraps 255 -> 0 naturally.
  always_comb begin
    pwm_pre_d  = pwm_pre_q;
    fade_pre_d = fade_pre_q;
    pwm_cnt_d  = pwm_cnt_q;
    if (pwm_tick_s) begin
      pwm_pre_d = '0;
      pwm_cnt_d = pwm_cnt_q + BRIGHT_ONE;
    end else begin
      pwm_pre_d = pwm_pre_q + PWM_INC;
      pwm_cnt_d = pwm_cnt_q;
    end
    if (fade_tick_s) begin
      fade_pre_d = '0;
    end else begin
      fade_pre_d = fade_pre_q + FADE_INC;
    end
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    led_fade_channel u_ch (
      .clk_i       (FPGA_CLK_50),
      .rst_ni      (rst_n),
      .req_i       (req_q[g]),
      .fade_tick_i (fade_tick_s),
      .pwm_cnt_i   (pwm_cnt_q),
      .led_d_o     (led_d_s[g]),
      .ramp_o      (ramp_s[g])
    );
  end

  // Input, timebase and output registers; the mirror shares led_out[0]'s next value.
  always_ff @(posedge FPGA_CLK_50) begin
    if (!rst_n) begin
      req_q         <= '0;
      pwm_pre_q     <= '0;
      fade_pre_q    <= '0;
      pwm_cnt_q     <= '0;
      led_out_q     <= '0;
      gpio_mirror_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      req_q         <= led_req;
      pwm_pre_q     <= pwm_pre_d;
      fade_pre_q    <= fade_pre_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_out_q     <= led_d_s;
      gpio_mirror_q <= led_d_s[0];
      busy_q        <= |ramp_s;
    end
  end

  assign led_out     = led_out_q;
  assign gpio_mirror = gpio_mirror_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: two instances (FADE_DIV 4 and 1024) against a cycle-level behavioural model.
module tb_led_fade_driver;

  localparam int S_OFF = 0, S_UP = 1, S_ON = 2, S_DOWN = 3;
  localparam int PDIV [2] = '{1, 1};
  localparam int FDIV [2] = '{4, 1024};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_a = 8'h00, req_b = 8'h00;
  logic [7:0] led_a, led_b;
  logic       gpio_a, gpio_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int edge_idx = -1;

  int         m_state  [2][8];
  int         m_bright [2][8];
  logic [7:0] m_req_q  [2];
  int         m_ppre   [2];
  int         m_fpre   [2];
  int         m_pcnt   [2];
  logic [7:0] m_led    [2];
  logic       m_busy   [2];

  always #5 clk = ~clk;

  led_fade_driver #(.N_LED(8), .PWM_DIV(1), .FADE_DIV(4)) dut_a (
    .FPGA_CLK_50(clk), .rst_n(rst_n), .led_req(req_a),
    .led_out(led_a), .gpio_mirror(gpio_a), .busy(busy_a)
  );

  led_fade_driver #(.N_LED(8), .PWM_DIV(1), .FADE_DIV(1024)) dut_b (
    .FPGA_CLK_50(clk), .rst_n(rst_n), .led_req(req_b),
    .led_out(led_b), .gpio_mirror(gpio_b), .busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lvl(input int b);
`ifdef LED_GAMMA_EN
    if (b == 255) return 255;
    return (b * b) / 256;
`else
    return b;
`endif
  endfunction

  // One clock edge of the whole driver, straight from the behavioural rules.
  task automatic model_step(input int k, input logic rst, input logic [7:0] req);
    bit ptick, ftick, r;
    logic [7:0] led_n;
    logic busy_n;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        m_state[k][i] = S_OFF;
        m_bright[k][i] = 0;
      end
      m_req_q[k] = 8'h00; m_ppre[k] = 0; m_fpre[k] = 0; m_pcnt[k] = 0;
      m_led[k] = 8'h00; m_busy[k] = 1'b0;
    end else begin
      ptick = (m_ppre[k] == PDIV[k] - 1);
      ftick = (m_fpre[k] == FDIV[k] - 1);
      busy_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
        led_n[i] = (lvl(m_bright[k][i]) == 255) || (lvl(m_bright[k][i]) > m_pcnt[k]);
        if (m_state[k][i] == S_UP || m_state[k][i] == S_DOWN) busy_n = 1'b1;
        r = m_req_q[k][i];
        case (m_state[k][i])
          S_OFF: if (r) m_state[k][i] = S_UP;
          S_UP: begin
            if (!r) m_state[k][i] = S_DOWN;
            else if (ftick) begin
              m_bright[k][i] = (m_bright[k][i] + 1 > 255) ? 255 : m_bright[k][i] + 1;
              if (m_bright[k][i] == 255) m_state[k][i] = S_ON;
            end
          end
          S_ON: if (!r) m_state[k][i] = S_DOWN;
          default: begin
            if (r) m_state[k][i] = S_UP;
            else if (ftick) begin
              m_bright[k][i] = (m_bright[k][i] - 1 < 0) ? 0 : m_bright[k][i] - 1;
              if (m_bright[k][i] == 0) m_state[k][i] = S_OFF;
            end
          end
        endcase
      end
      m_led[k] = led_n;
      m_busy[k] = busy_n;
      m_ppre[k] = ptick ? 0 : m_ppre[k] + 1;
      m_fpre[k] = ftick ? 0 : m_fpre[k] + 1;
      if (ptick) m_pcnt[k] = (m_pcnt[k] + 1) % 256;
      m_req_q[k] = req;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_n, req_a);
    model_step(1, rst_n, req_b);
    if (!rst_n) edge_idx = -1; else edge_idx++;
    #1;
    check_eq("a_led", 32'(led_a), 32'(m_led[0]));
    check_eq("a_gpio", 32'(gpio_a), 32'(m_led[0][0]));
    check_eq("a_busy", 32'(busy_a), 32'(m_busy[0]));
    check_eq("b_led", 32'(led_b), 32'(m_led[1]));
    check_eq("b_gpio", 32'(gpio_b), 32'(m_led[1][0]));
    check_eq("b_busy", 32'(busy_b), 32'(m_busy[1]));
  endtask

  task automatic wait_a_idle(input string tag, input int bound);
    for (int n = 0; n < bound && busy_a; n++) tick();
    check_eq(tag, 32'(busy_a), 32'd0);
  endtask

  task automatic duty_b(input string tag, input int exp);
    int highs = 0;
    repeat (2) tick();
    for (int n = 0; n < 256; n++) begin
      tick();
      if (led_b[0]) highs++;
    end
    check_eq(tag, 32'(highs), 32'(exp));
  endtask

  initial begin
    int first_hi, len, n, seg;

    // Reset held with all requests asserted.
    req_a = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("rst_led", 32'(led_a), 32'd0);
      check_eq("rst_gpio", 32'(gpio_a), 32'd0);
      check_eq("rst_busy", 32'(busy_a), 32'd0);
    end
    rst_n = 1'b1;
    first_hi = -1;
    for (int c = 0; c < 20 && first_hi < 0; c++) begin
      tick();
      if (busy_a) first_hi = edge_idx;
    end
    check_eq("busy_rise_edge", 32'(first_hi), 32'd2);
    req_a = 8'h00;
    wait_a_idle("idle_after_rst", 200);

    // Full ramp on channel 0.
    req_a = 8'h01;
    for (int c = 0; c < 10 && !busy_a; c++) tick();
    check_eq("ramp_start", 32'(busy_a), 32'd1);
    len = 0;
    for (int c = 0; c < 1500 && busy_a; c++) begin
      tick();
      if (busy_a) len++;
    end
    check_eq("ramp_done", 32'(busy_a), 32'd0);
    check_eq("ramp_len", 32'(len >= 1014 && len <= 1024), 32'd1);
    for (int c = 0; c < 300; c++) begin
      tick();
      check_eq("on_led", 32'(led_a), 32'h01);
      check_eq("on_gpio", 32'(gpio_a), 32'd1);
    end

    // Reversal of channel 3 at bright 100.
    req_a = 8'h09;
    for (int c = 0; c < 1000 && m_bright[0][3] != 100; c++) tick();
    req_a = 8'h01;
    n = 0;
    for (int c = 1; c <= 600; c++) begin
      tick();
      if (!busy_a) begin n = c; break; end
    end
    check_eq("rev_fall_edge", 32'(n), 32'd401);

    // Reset in the middle of a ramp.
    req_a = 8'h00;
    wait_a_idle("idle_before_mid", 1500);
    req_a = 8'hFF;
    for (int c = 0; c < 600 && m_bright[0][1] != 50; c++) tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_led", 32'(led_a), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (300) tick();

    // Random request patterns.
    n = 0;
    while (n < 3000) begin
      req_a = 8'($urandom);
      seg = $urandom_range(1, 300);
      repeat (seg) tick();
      n += seg;
    end
    req_a = 8'h00;
    wait_a_idle("idle_after_rand", 1500);

    // Duty measurements on the slow instance.
    req_b = 8'h01;
    for (int c = 0; c < 20000 && m_bright[1][0] != 16; c++) tick();
`ifdef LED_GAMMA_EN
    duty_b("duty16", 1);
`else
    duty_b("duty16", 16);
`endif
    for (int c = 0; c < 50000 && m_bright[1][0] != 64; c++) tick();
`ifdef LED_GAMMA_EN
    duty_b("duty64", 16);
`else
    duty_b("duty64", 64);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
